// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the serial-to-parallel deserializer.
//   IDLE / SHIFT : frame-assembly states (1-bit encoding).
//   sipo_cnt_w() : width of the bit counter, able to hold 0..WIDTH.
package sipo_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  function automatic int sipo_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Bus interface for sipo_deserializer.
//   sin, sin_valid, sof : serial input side (driven by master).
//   q, q_valid, q_ready : parallel word handshake to the consumer.
//   busy, overrun       : status outputs from the deserializer.
// The deserializer connects through the slave modport; the producer/consumer
// side through the master modport.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
);

  logic             sin;
  logic             sin_valid;
  logic             sof;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic             busy;
  logic             overrun;

  modport master (
    output sin, sin_valid, sof, q_ready,
    input  q, q_valid, busy, overrun
  );

  modport slave (
    input  sin, sin_valid, sof, q_ready,
    output q, q_valid, busy, overrun
  );

endinterface

// File: rtl/sipo_deserializer_counter.sv
// Bit counter for the deserializer.
//   clk, reset : clock and synchronous active-high reset.
//   clr        : return the count to 0 (word completed).
//   load1      : set the count to 1 (start-of-frame bit accepted).
//   inc        : count one more accepted bit.
//   term       : the next increment brings the count to WIDTH, i.e. the
//                bit being accepted now completes the word.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = sipo_cnt_w(WIDTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic load1,
  input  logic inc,
  output logic term
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = CNT_W'(1);
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Completion is flagged one count early so the word can be transferred on
  // the same edge that accepts its last bit, without a WIDTH state ever
  // being held.
  assign term = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer with start-of-frame alignment, selectable
// bit order, a single-entry output slot with valid/ready handshake and a
// sticky overrun flag.
//   clk, reset : clock and synchronous active-high reset (highest priority).
//   bus        : slave side of sipo_deserializer_if
//                (sin/sin_valid/sof in, q/q_valid out, q_ready in,
//                 busy/overrun out).
// Parameters: WIDTH (>= 2) word width; MSB_FIRST = 1 puts the first serial
// bit in q[WIDTH-1], 0 puts it in q[0].
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                clk,
  input logic                reset,
  sipo_deserializer_if.slave bus
);

  localparam int CNT_W = sipo_cnt_w(WIDTH);

  logic [0:0]       state_q,   state_d;
  logic [WIDTH-1:0] shift_q,   shift_d;
  logic [WIDTH-1:0] word_q,    word_d;
  logic             q_valid_q, q_valid_d;
  logic             overrun_q, overrun_d;

  logic             start;
  logic             shift_bit;
  logic             complete;
  logic             slot_free;
  logic             term;
  logic [WIDTH-1:0] shifted;

  // MSB-first shifts left with the new bit at the LSB; LSB-first shifts
  // right with the new bit at the MSB. After WIDTH bits the first bit sits
  // at q[WIDTH-1] or q[0] respectively.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                input logic b);
    if (MSB_FIRST) begin
      return {sr[WIDTH-2:0], b};
    end else begin
      return {b, sr[WIDTH-1:1]};
    end
  endfunction

  // sof restarts alignment in either state; a partial word is dropped.
  assign start     = bus.sin_valid & bus.sof;
  assign shift_bit = (state_q == SHIFT) & bus.sin_valid & ~bus.sof;
  assign complete  = shift_bit & term;
  assign slot_free = ~q_valid_q | bus.q_ready;
  assign shifted   = shift_in(shift_q, bus.sin);

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (complete),
    .load1 (start),
    .inc   (shift_bit),
    .term  (term)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    word_d    = word_q;
    q_valid_d = q_valid_q;
    overrun_d = overrun_q;

    if (start) begin
      shift_d = shift_in('0, bus.sin);
      state_d = SHIFT;
    end else if (shift_bit) begin
      shift_d = shifted;
      if (term) begin
        state_d = IDLE;
      end
    end

    // A completing word wins over a plain consume: if the consumer takes the
    // old word this cycle the new one moves straight in and q_valid stays 1.
    if (complete) begin
      if (slot_free) begin
        word_d    = shifted;
        q_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (q_valid_q & bus.q_ready) begin
      q_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      word_q    <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.q       = word_q;
  assign bus.q_valid = q_valid_q;
  assign bus.busy    = (state_q == SHIFT);
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench: two deserializers (MSB-first and LSB-first) see the same
// serial stream; expected words are queued per instance and popped by a
// monitor on every q_valid & q_ready handshake.
module tb_sipo_deserializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sin = 1'b0;
  logic sin_valid = 1'b0;
  logic sof = 1'b0;
  logic q_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [3:0] qm[$];
  logic [3:0] ql[$];

  always #5 clk = ~clk;

  sipo_deserializer_if #(.WIDTH(4)) ifm ();
  sipo_deserializer_if #(.WIDTH(4)) ifl ();

  assign ifm.sin = sin;  assign ifm.sin_valid = sin_valid;
  assign ifm.sof = sof;  assign ifm.q_ready   = q_ready;
  assign ifl.sin = sin;  assign ifl.sin_valid = sin_valid;
  assign ifl.sof = sof;  assign ifl.q_ready   = q_ready;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (ifm.slave)
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (ifl.slave)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic b, input logic s);
    sin = b; sin_valid = 1'b1; sof = s;
    @(posedge clk); #1;
    sin_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic idle(input int n);
    sin_valid = 1'b0; sof = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic [3:0] exp_qm, input logic [3:0] exp_ql,
                            input logic v, input logic b, input logic o);
    chk({tag, "_q_m"}, 8'(ifm.q), 8'(exp_qm));
    chk({tag, "_q_l"}, 8'(ifl.q), 8'(exp_ql));
    chk({tag, "_qvalid"}, {6'b0, ifm.q_valid, ifl.q_valid}, {6'b0, v, v});
    chk({tag, "_busy"}, {6'b0, ifm.busy, ifl.busy}, {6'b0, b, b});
    chk({tag, "_overrun"}, {6'b0, ifm.overrun, ifl.overrun}, {6'b0, o, o});
  endtask

  // Monitor: every accepted word must match the head of its queue.
  always @(negedge clk) begin
    if (!reset && ifm.q_valid && ifm.q_ready) begin
      if (qm.size() == 0) begin
        checks++; failures++;
        $display("FAIL mon_m: unexpected word %b at %0t", ifm.q, $time);
      end else begin
        chk("mon_m", 8'(ifm.q), 8'(qm.pop_front()));
      end
    end
    if (!reset && ifl.q_valid && ifl.q_ready) begin
      if (ql.size() == 0) begin
        checks++; failures++;
        $display("FAIL mon_l: unexpected word %b at %0t", ifl.q, $time);
      end else begin
        chk("mon_l", 8'(ifl.q), 8'(ql.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_status("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Basic: 1,0,1,1 back to back, consumer always ready.
    q_ready = 1'b1;
    qm.push_back(4'b1011); ql.push_back(4'b1101);
    send(1, 1); send(0, 0); send(1, 0);
    chk("basic_busy_mid", {7'b0, ifm.busy}, 8'd1);
    send(1, 0);
    chk_status("basic_done", 4'b1011, 4'b1101, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("basic_qvalid_clr", {6'b0, ifm.q_valid, ifl.q_valid}, 8'd0);

    // Gaps between bits: state must hold, busy stays high.
    qm.push_back(4'b1011); ql.push_back(4'b1101);
    send(1, 1); idle(2);
    chk("gap_busy1", {6'b0, ifm.busy, ifl.busy}, 8'b11);
    send(0, 0); idle(1);
    send(1, 0); idle(3);
    chk("gap_busy3", {6'b0, ifm.busy, ifl.busy}, 8'b11);
    send(1, 0);
    chk_status("gap_done", 4'b1011, 4'b1101, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Resync: aborted partial word, then a complete one.
    qm.push_back(4'b0001); ql.push_back(4'b1000);
    send(1, 1); send(1, 0);
    send(0, 1); send(0, 0); send(0, 0); send(1, 0);
    chk_status("resync", 4'b0001, 4'b1000, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Backpressure: second word dropped, overrun sticky.
    q_ready = 1'b0;
    qm.push_back(4'b1010); ql.push_back(4'b0101);
    send(1, 1); send(0, 0); send(1, 0); send(0, 0);
    send(0, 1); send(1, 0); send(1, 0); send(0, 0);
    chk_status("bp_full", 4'b1010, 4'b0101, 1'b1, 1'b0, 1'b1);
    idle(2);
    chk("bp_hold_q", 8'(ifm.q), 8'b1010);
    q_ready = 1'b1;
    idle(1);
    chk_status("bp_drain", 4'b1010, 4'b0101, 1'b0, 1'b0, 1'b1);

    // Same-cycle consume and complete.
    pulse_reset();
    chk("pre_same_overrun", {6'b0, ifm.overrun, ifl.overrun}, 8'd0);
    q_ready = 1'b0;
    qm.push_back(4'b1100); ql.push_back(4'b0011);
    send(1, 1); send(1, 0); send(0, 0); send(0, 0);
    qm.push_back(4'b0011); ql.push_back(4'b1100);
    send(0, 1); send(0, 0); send(1, 0);
    q_ready = 1'b1;
    send(1, 0);
    chk_status("same_cycle", 4'b0011, 4'b1100, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("same_drained", {6'b0, ifm.q_valid, ifl.q_valid}, 8'd0);

    // Mid-word reset, with a sof bit offered during reset.
    send(1, 1); send(0, 0);
    reset = 1'b1; sin = 1'b1; sin_valid = 1'b1; sof = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; sin_valid = 1'b0; sof = 1'b0;
    chk_status("mid_reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    send(1, 0); send(1, 0); send(1, 0);
    chk_status("stray", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    qm.push_back(4'b0101); ql.push_back(4'b1010);
    send(0, 1); send(1, 0); send(0, 0); send(1, 0);
    chk_status("fresh", 4'b0101, 4'b1010, 1'b1, 1'b0, 1'b0);
    idle(3);

    chk("queue_m_empty", 8'(qm.size()), 8'd0);
    chk("queue_l_empty", 8'(ql.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
